// File: rtl/muldiv_unit_if.sv
// Start/valid handshake between the control unit (master) and the mul/div
// unit (slave). Operands and funct3 travel with start; the result returns with valid.
interface muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b,
        input  busy, valid, result
    );

    modport slave (
        input  start, funct3, op_a, op_b,
        output busy, valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider sharing one 2*XLEN working register and one iteration counter.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   work_q, work_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2:0]          f3_q, f3_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Decode of an incoming request
    logic            sa_n, sb_n, spec_n;
    logic [XLEN-1:0] mag_a, mag_b, spec_val;

    always_comb begin
        sa_n   = bus.op_a[XLEN-1] & (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
                                     bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
        sb_n   = bus.op_b[XLEN-1] & (bus.funct3 == 3'b001 || bus.funct3 == 3'b100 ||
                                     bus.funct3 == 3'b110);
        mag_a  = sa_n ? -bus.op_a : bus.op_a;
        mag_b  = sb_n ? -bus.op_b : bus.op_b;
        spec_n = bus.funct3[2] & ((bus.op_b == '0) ||
                 (!bus.funct3[0] && bus.op_a == MIN_VAL && bus.op_b == '1));
        if (bus.op_b == '0)
            spec_val = bus.funct3[1] ? bus.op_a : '1;
        else
            spec_val = bus.funct3[1] ? '0 : MIN_VAL;
    end

    // One multiply step: conditional add into the upper half with a carry bit, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     rem_sh, rem_sub;
    logic              rem_ge;
    logic [2*XLEN-1:0] div_step;

    always_comb begin
        mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {mul_sum, work_q[XLEN-1:1]};
        rem_sh   = work_q[2*XLEN-1:XLEN-1];
        rem_sub  = rem_sh - {1'b0, opnd_q};
        rem_ge   = rem_sh >= {1'b0, opnd_q};
        div_step = {rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0], work_q[XLEN-2:0], rem_ge};
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -work_q : work_q;
        quot_fix = (sa_q ^ sb_q) ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
        rem_fix  = sa_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        spec_d   = spec_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    f3_d   = bus.funct3;
                    sa_d   = sa_n;
                    sb_d   = sb_n;
                    spec_d = spec_n;
                    cnt_d  = '0;
                    if (spec_n) begin
                        work_d  = {{XLEN{1'b0}}, spec_val};
                        state_d = SIGN;
                    end else if (bus.funct3[2]) begin
                        work_d  = {{XLEN{1'b0}}, mag_a};
                        opnd_d  = mag_b;
                        state_d = CALC;
                    end else begin
                        work_d  = {{XLEN{1'b0}}, mag_b};
                        opnd_d  = mag_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                work_d = f3_q[2] ? div_step : mul_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST)
                    state_d = SIGN;
            end
            SIGN: begin
                if (spec_q)
                    result_d = work_q[XLEN-1:0];
                else begin
                    case (f3_q)
                        3'b000:                 result_d = prod_fix[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         result_d = quot_fix;
                        default:                result_d = rem_fix;
                    endcase
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            spec_q   <= spec_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == CALC) || (state_q == SIGN);
    assign bus.valid  = (state_q == DONE);
    assign bus.result = result_q;
endmodule
